// File: rtl/burst_mem_pkg.sv
// Shared types and default sizes for the burst memory.
// Used with or without the BURST_MEM_PARITY_EN build macro.
package burst_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned LEN_WIDTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

endpackage

// File: rtl/burst_mem_array.sv
// Single-port word storage: synchronous write, combinational read.
// BURST_MEM_PARITY_EN adds an even-parity bit per word and a parity-error output.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef BURST_MEM_PARITY_EN
  output logic                  rperr,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

`ifdef BURST_MEM_PARITY_EN
  // Word layout is {parity, data}; a clean word XORs to zero.
  logic [DATA_WIDTH:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= {^wdata, wdata};
    end
  end

  assign rdata = mem[addr][DATA_WIDTH-1:0];
  assign rperr = ^mem[addr];
`else
  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
`endif

endmodule

// File: rtl/burst_mem.sv
// Burst read/write memory with a request channel, write beats and a ready/valid read stream.
// Build with BURST_MEM_PARITY_EN to report stored-parity errors on rd_perr.
module burst_mem
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  beats_left_q;
  logic                  req_ready_q;
  logic                  wr_ready_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  perr_q;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_perr;

  // One shared address: the request address in IDLE prefetches the first read beat,
  // and in READ the next word is looked up so it can follow a handshake without a bubble.
  always_comb begin
    mem_addr = req_addr;
    unique case (state_q)
      WRITE:   mem_addr = cur_addr_q;
      READ:    mem_addr = cur_addr_q + 1'b1;
      default: mem_addr = req_addr;
    endcase
  end

  // Gated by the registered state, so an asynchronous reset blocks any further write.
  assign mem_we = (state_q == WRITE) && wr_valid;

  burst_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wr_data),
`ifdef BURST_MEM_PARITY_EN
    .rperr (mem_perr),
`endif
    .rdata (mem_rdata)
  );

`ifndef BURST_MEM_PARITY_EN
  assign mem_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      req_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      perr_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            cur_addr_q   <= req_addr;
            beats_left_q <= req_len;
            req_ready_q  <= 1'b0;
            if (req_write) begin
              state_q    <= WRITE;
              wr_ready_q <= 1'b1;
            end else begin
              state_q    <= READ;
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem_rdata;
              perr_q     <= mem_perr;
            end
          end
        end
        WRITE: begin
          if (wr_valid) begin
            cur_addr_q <= cur_addr_q + 1'b1;
            if (beats_left_q == '0) begin
              state_q     <= IDLE;
              wr_ready_q  <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              beats_left_q <= beats_left_q - 1'b1;
            end
          end
        end
        READ: begin
          // rd_valid_q is always set while in READ.
          if (rd_ready) begin
            if (beats_left_q == '0) begin
              state_q     <= IDLE;
              rd_valid_q  <= 1'b0;
              perr_q      <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              cur_addr_q   <= cur_addr_q + 1'b1;
              beats_left_q <= beats_left_q - 1'b1;
              rd_data_q    <= mem_rdata;
              perr_q       <= mem_perr;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

`ifdef BURST_MEM_PARITY_EN
  assign rd_perr = perr_q;
`else
  assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem.sv
// Self-checking bench for burst_mem: queue-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized bursts.
module tb_burst_mem;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 2;
  localparam int unsigned DEPTH = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_perr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  burst_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_perr   (rd_perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory image plus queues of addresses still owed by the active burst.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_bad [DEPTH];
  int            wq[$];
  int            rq[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      wq.delete();
      rq.delete();
    end
    check("req_ready", int'(req_ready), int'(wq.size() == 0 && rq.size() == 0));
    check("wr_ready", int'(wr_ready), int'(wq.size() != 0));
    check("rd_valid", int'(rd_valid), int'(rq.size() != 0));
    if (rq.size() != 0) begin
      check("rd_data", int'(rd_data), int'(m_mem[rq[0]]));
      check("rd_perr", int'(rd_perr), int'(m_bad[rq[0]]));
    end else begin
      check("rd_perr_idle", int'(rd_perr), 0);
    end
    if (!rst_n) check("rd_data_reset", int'(rd_data), 0);
    // Predict the effect of the coming rising edge from the inputs now held stable.
    if (rst_n) begin
      if (wq.size() != 0) begin
        if (wr_valid) begin
          m_mem[wq[0]] = wr_data;
          m_bad[wq[0]] = 1'b0;
          wq.delete(0);
        end
      end else if (rq.size() != 0) begin
        if (rd_ready) rq.delete(0);
      end else if (req_valid) begin
        for (int i = 0; i <= int'(req_len); i++) begin
          if (req_write) wq.push_back((int'(req_addr) + i) % DEPTH);
          else rq.push_back((int'(req_addr) + i) % DEPTH);
        end
      end
    end
  end

  logic [DW-1:0] wbuf [4];
  logic [DW-1:0] cap [4];
  int            cap_cyc [4];
  bit            cap_perr [4];
  logic [DW-1:0] hold_vals[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit wr, input int addr, input int len);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("req_accept_timeout", int'(req_ready), 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_beats(input int len, input bit gaps);
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        wr_data  = DW'($urandom);
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic write_burst(input int addr, input int len, input bit gaps);
    request(1'b1, addr, len);
    write_beats(len, gaps);
  endtask

  task automatic collect(input int len, input int hold, input bit randready);
    int got = 0;
    int n   = 0;
    int h   = hold;
    hold_vals.delete();
    while (got <= len && n < 300) begin
      rd_ready = randready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (h > 0 && rd_valid) begin
        rd_ready = 1'b0;
        hold_vals.push_back(rd_data);
        h--;
      end
      if (rd_valid && rd_ready) begin
        cap[got]      = rd_data;
        cap_cyc[got]  = cyc;
        cap_perr[got] = rd_perr;
        got++;
      end
      tick();
      n++;
    end
    rd_ready = 1'b0;
    if (got <= len) check("rd_burst_timeout", got, len + 1);
  endtask

  task automatic read_burst(input int addr, input int len, input int hold, input bit randready);
    request(1'b0, addr, len);
    check("rd_first_latency", int'(rd_valid), 1);
    collect(len, hold, randready);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    tick();
    tick();
    check("reset_req_ready", int'(req_ready), 1);
    check("reset_wr_ready", int'(wr_ready), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    rst_n = 1'b1;
    tick();

    // Fill all words so every later read has a known model value.
    for (int a = 0; a < int'(DEPTH); a += 4) begin
      for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
      write_burst(a, 3, 1'b0);
    end

    // Basic write then read with back-to-back beats.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(3, 3, 1'b0);
    read_burst(3, 3, 0, 1'b0);
    check("basic_beat0", int'(cap[0]), 'h11);
    check("basic_beat1", int'(cap[1]), 'h22);
    check("basic_beat2", int'(cap[2]), 'h33);
    check("basic_beat3", int'(cap[3]), 'h44);
    for (int i = 0; i < 3; i++) check("basic_no_bubble", cap_cyc[i + 1] - cap_cyc[i], 1);
    tick();
    check("basic_idle_after", int'(req_ready), 1);

    // Address wrap from 31 to 0.
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    write_burst(30, 3, 1'b0);
    read_burst(0, 0, 0, 1'b0);
    check("wrap_addr0", int'(cap[0]), 'hA2);
    read_burst(1, 0, 0, 1'b0);
    check("wrap_addr1", int'(cap[0]), 'hA3);
    read_burst(31, 0, 0, 1'b0);
    check("wrap_addr31", int'(cap[0]), 'hA1);

    // Backpressure: consumer stalls three cycles on the first beat.
    read_burst(3, 1, 3, 1'b0);
    check("bp_hold_count", hold_vals.size(), 3);
    foreach (hold_vals[i]) check("bp_hold_stable", int'(hold_vals[i]), 'h11);
    check("bp_beat0", int'(cap[0]), 'h11);
    check("bp_beat1", int'(cap[1]), 'h22);

    // Request held pending during a write burst.
    wbuf[0] = 8'h55; wbuf[1] = 8'h66; wbuf[2] = 8'h77; wbuf[3] = 8'h88;
    request(1'b1, 12, 3);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = AW'(12);
    req_len   = LW'(3);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      check("busy_req_ready", int'(req_ready), 0);
      tick();
    end
    wr_valid = 1'b0;
    check("pending_first_idle", int'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    check("pending_accepted", int'(rd_valid), 1);
    collect(3, 0, 1'b0);
    check("pending_beat0", int'(cap[0]), 'h55);
    check("pending_beat3", int'(cap[3]), 'h88);

    // Reset in the middle of a write burst.
    wbuf[0] = 8'h5A; wbuf[1] = 8'h5B; wbuf[2] = 8'h5C; wbuf[3] = 8'h5D;
    write_burst(20, 3, 1'b0);
    request(1'b1, 20, 3);
    wr_valid = 1'b1;
    wr_data  = 8'hC1;
    tick();
    wr_data  = 8'hC2;
    tick();
    rst_n   = 1'b0;
    wr_data = 8'hC3;
    #1;
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_wr_ready", int'(wr_ready), 0);
    check("midrst_rd_valid", int'(rd_valid), 0);
    check("midrst_rd_data", int'(rd_data), 0);
    check("midrst_rd_perr", int'(rd_perr), 0);
    tick();
    tick();
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    read_burst(20, 3, 0, 1'b0);
    check("midrst_kept0", int'(cap[0]), 'hC1);
    check("midrst_kept1", int'(cap[1]), 'hC2);
    check("midrst_untouched2", int'(cap[2]), 'h5C);
    check("midrst_untouched3", int'(cap[3]), 'h5D);

`ifdef BURST_MEM_PARITY_EN
    // Corrupt one stored data bit and confirm only that word reports a parity error.
    tick();
    dut.u_array.mem[5][0] = ~dut.u_array.mem[5][0];
    m_mem[5][0] = ~m_mem[5][0];
    m_bad[5]    = 1'b1;
    read_burst(5, 0, 0, 1'b0);
    check("parity_bad", int'(cap_perr[0]), 1);
    read_burst(6, 0, 0, 1'b0);
    check("parity_good", int'(cap_perr[0]), 0);
`endif

    // Randomized bursts with write gaps and random read backpressure.
    for (int t = 0; t < 60; t++) begin
      int a;
      int l;
      a = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) wbuf[i] = DW'($urandom);
        write_burst(a, l, 1'b1);
      end else begin
        read_burst(a, l, 0, 1'b1);
      end
      if ($urandom_range(0, 2) == 0) tick();
    end

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
